banco_antirrebote_n: RTL

- Parametrised N-channel debounce bank for board switches and buttons. Successor of the fixed 4-switch/5-button bank.
- Each channel has: 2-flop synchroniser, tick-based stable-sample debouncer, one-cycle rise/fall strobes, and optional hold-to-auto-repeat (masked per channel).
- Sits between the board pins and the clock/date/timer configuration FSMs. Those FSMs consume `press` strobes instead of raw levels.

---
 rtl/banco_antirrebote_n_pkg.sv | 29 ++
 rtl/antirrebote_canal.sv | 144 ++++++++++++++
 rtl/banco_antirrebote_n.sv | 63 ++++++
 3 files changed

// File: rtl/banco_antirrebote_n_pkg.sv
// Shared types and channel map for the switch/button debounce bank.
// Channel indices follow the board wiring: four config switches, then the five-way pad.
package banco_antirrebote_n_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_st_t;

  typedef struct packed {
    logic db;
    logic rise;
    logic fall;
    logic rep;
    logic press;
  } chan_out_t;

  localparam int SW_HORA    = 0;
  localparam int SW_FECHA   = 1;
  localparam int SW_TIMER   = 2;
  localparam int SW_FMT     = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_CENTER = 8;

endpackage

// File: rtl/antirrebote_canal.sv
// One debounce channel: 2-flop synchroniser, tick-qualified debouncer,
// edge strobes and, when REP_EN is set, a hold-to-auto-repeat FSM.
module antirrebote_canal
  import banco_antirrebote_n_pkg::*;
#(
  parameter int DB_TICKS   = 20,
  parameter int HOLD_TICKS = 500,
  parameter int REP_TICKS  = 100,
  parameter bit REP_EN     = 1'b0
)(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_raw,
  input  logic      i_tick,
  output chan_out_t o_ch
);

  localparam int            DW      = $clog2(DB_TICKS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS - 1);

  if (DB_TICKS < 1) begin : g_chk_db
    $error("DB_TICKS must be >= 1");
  end
  if (HOLD_TICKS < 1 || REP_TICKS < 1) begin : g_chk_rep
    $error("HOLD_TICKS and REP_TICKS must be >= 1");
  end

  logic [1:0]    r_sync;
  logic          w_s;
  logic          r_db;
  logic [DW-1:0] r_dcnt;
  logic          w_upd;
  logic          w_rise;
  logic          w_fall;
  logic          w_rep_hit;
  logic          r_rise;
  logic          r_fall;
  logic          r_rep;
  logic          r_press;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_raw};
  end

  assign w_s    = r_sync[1];
  assign w_upd  = (w_s != r_db) && i_tick && (r_dcnt == DB_LAST);
  assign w_rise = w_upd &  w_s;
  assign w_fall = w_upd & ~w_s;

  // Any sample matching the current level throws away partial qualification.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db   <= 1'b0;
      r_dcnt <= '0;
    end else if (w_s == r_db) begin
      r_dcnt <= '0;
    end else if (i_tick) begin
      if (r_dcnt == DB_LAST) begin
        r_db   <= w_s;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  if (REP_EN) begin : g_rep
    localparam int            HMAX      = (HOLD_TICKS > REP_TICKS) ? HOLD_TICKS : REP_TICKS;
    localparam int            HW        = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REP_TICKS - 1);

    rep_st_t       r_st;
    logic [HW-1:0] r_hcnt;

    // A release on the same tick as a due repeat wins: no repeat is emitted.
    assign w_rep_hit = i_tick && !w_fall &&
                       (((r_st == HOLD)   && (r_hcnt == HOLD_LAST)) ||
                        ((r_st == REPEAT) && (r_hcnt == REP_LAST)));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_st   <= IDLE;
        r_hcnt <= '0;
      end else if (w_fall) begin
        r_st   <= IDLE;
        r_hcnt <= '0;
      end else begin
        case (r_st)
          IDLE: begin
            if (w_rise) begin
              r_st   <= HOLD;
              r_hcnt <= '0;
            end
          end
          HOLD: begin
            if (i_tick) begin
              if (r_hcnt == HOLD_LAST) begin
                r_st   <= REPEAT;
                r_hcnt <= '0;
              end else begin
                r_hcnt <= r_hcnt + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (i_tick) begin
              if (r_hcnt == REP_LAST) r_hcnt <= '0;
              else                    r_hcnt <= r_hcnt + 1'b1;
            end
          end
          default: begin
            r_st   <= IDLE;
            r_hcnt <= '0;
          end
        endcase
      end
    end
  end else begin : g_norep
    assign w_rep_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_rep   <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_rep   <= w_rep_hit;
      r_press <= w_rise | w_rep_hit;
    end
  end

  assign o_ch.db    = r_db;
  assign o_ch.rise  = r_rise;
  assign o_ch.fall  = r_fall;
  assign o_ch.rep   = r_rep;
  assign o_ch.press = r_press;

endmodule

// File: rtl/banco_antirrebote_n.sv
// N-channel debounce bank: one shared sample-tick divider feeding an array of
// independent channels. Downstream config FSMs consume press, not raw levels.
module banco_antirrebote_n
  import banco_antirrebote_n_pkg::*;
#(
  parameter int              N_CH       = 9,
  parameter int              TICK_DIV   = 100000,
  parameter int              DB_TICKS   = 20,
  parameter int              HOLD_TICKS = 500,
  parameter int              REP_TICKS  = 100,
  parameter logic [N_CH-1:0] REP_MASK   = 9'h1F0
)(
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in_raw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] rep,
  output logic [N_CH-1:0] press
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_chk_div
    $error("TICK_DIV must be >= 2");
  end

  logic [TW-1:0] r_tcnt;
  logic          w_tick;
  chan_out_t     w_ch [N_CH];

  assign w_tick = (r_tcnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_tcnt <= '0;
    else if (w_tick) r_tcnt <= '0;
    else             r_tcnt <= r_tcnt + 1'b1;
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    antirrebote_canal #(
      .DB_TICKS  (DB_TICKS),
      .HOLD_TICKS(HOLD_TICKS),
      .REP_TICKS (REP_TICKS),
      .REP_EN    (REP_MASK[gi])
    ) u_canal (
      .clk   (clk),
      .reset (reset),
      .i_raw (in_raw[gi]),
      .i_tick(w_tick),
      .o_ch  (w_ch[gi])
    );

    assign db[gi]    = w_ch[gi].db;
    assign rise[gi]  = w_ch[gi].rise;
    assign fall[gi]  = w_ch[gi].fall;
    assign rep[gi]   = w_ch[gi].rep;
    assign press[gi] = w_ch[gi].press;
  end

endmodule
